// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares one single-ported, fixed-latency unified memory between the
//   instruction-fetch port (if_*) and the MEM-stage data port (dm_*).
//   In IDLE a request is granted combinationally in the same cycle and the
//   winner's fields are driven straight onto mem_*. The arbiter then sits in
//   BUSY for MEM_LAT cycles. The owner's rvalid pulses on the last BUSY cycle
//   and carries mem_rdata. Any requester without a grant must stall.
//
//   Data accesses win by default. Fetch is forced through once STARVE_LIMIT
//   consecutive data grants have been issued while fetch was waiting.
//
// Parameters:
//   AW           address width of both ports
//   MEM_LAT      cycles from mem_en to mem_rdata valid (1..15)
//   STARVE_LIMIT data grants with if_req pending before fetch is forced (>=1)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch grant, response pulse, instruction
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_size            data request and qualifiers, held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata   data grant, response pulse / store ack, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_size          memory macro strobe and request fields
//   mem_rdata                   memory read data, valid MEM_LAT cycles after mem_en
//   if_wait_cnt/dm_wait_cnt     wait-cycle counters (see macro below)
//
// Configuration:
//   ARB_PERF_CNT_EN  when defined, the wait counters count the cycles each port
//                    spends requesting without a grant; they saturate and are
//                    cleared by reset. When undefined, both read constant 0.
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int AW           = 64,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [63:0]   dm_wdata,
  input  logic [3:0]    dm_size,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [63:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  output logic [3:0]    mem_size,
  input  logic [63:0]   mem_rdata,
  output logic [31:0]   if_wait_cnt,
  output logic [31:0]   dm_wait_cnt
);

  // Streak counter is at least 3 bits wide and large enough to hold STARVE_LIMIT.
  localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    LAT_INIT   = 4'(MEM_LAT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state_q;
  logic [3:0]    lat_cnt_q;
  logic          own_dm_q;
  logic [SW-1:0] streak_q;

  logic idle_w;
  logic if_first_w;
  logic grant_dm_w;
  logic grant_if_w;
  logic rsp_w;

  // Grants are only possible in IDLE and never while reset is asserted, so all
  // outputs are quiet during reset even if requests are already present.
  assign idle_w     = (state_q == IDLE) && !reset;
  assign if_first_w = if_req && (streak_q == STARVE_MAX);
  assign grant_dm_w = idle_w && dm_req && !if_first_w;
  assign grant_if_w = idle_w && if_req && !grant_dm_w;

  // The last BUSY cycle is the one in which mem_rdata is valid.
  assign rsp_w = (state_q == BUSY) && (lat_cnt_q == 4'd1) && !reset;

  assign if_gnt    = grant_if_w;
  assign dm_gnt    = grant_dm_w;
  assign mem_en    = grant_dm_w || grant_if_w;
  assign mem_we    = grant_dm_w && dm_we;
  assign mem_addr  = grant_dm_w ? dm_addr : (grant_if_w ? if_addr : '0);
  assign mem_wdata = grant_dm_w ? dm_wdata : '0;
  // Fetches always read one 32-bit instruction.
  assign mem_size  = grant_dm_w ? dm_size : (grant_if_w ? 4'd4 : 4'd0);

  assign if_rvalid = rsp_w && !own_dm_q;
  assign dm_rvalid = rsp_w && own_dm_q;
  assign if_rdata  = if_rvalid ? mem_rdata[31:0] : 32'd0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : 64'd0;

  // Arbiter FSM, latency counter, owner flag and starvation streak.
  // The streak only grows on data grants that bypass a waiting fetch; it is
  // cleared whenever fetch is served or stops asking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      own_dm_q  <= 1'b0;
      streak_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dm_w || grant_if_w) begin
            state_q   <= BUSY;
            lat_cnt_q <= LAT_INIT;
            own_dm_q  <= grant_dm_w;
          end
        end
        BUSY: begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
          if (lat_cnt_q == 4'd1) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (!if_req || grant_if_w) begin
        streak_q <= '0;
      end else if (grant_dm_w && (streak_q != STARVE_MAX)) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_wait_q;
  logic [31:0] dm_wait_q;

  // Saturating counts of cycles spent requesting without a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_wait_q <= 32'd0;
      dm_wait_q <= 32'd0;
    end else begin
      if (if_req && !grant_if_w && (if_wait_q != 32'hFFFF_FFFF)) begin
        if_wait_q <= if_wait_q + 32'd1;
      end
      if (dm_req && !grant_dm_w && (dm_wait_q != 32'hFFFF_FFFF)) begin
        dm_wait_q <= dm_wait_q + 32'd1;
      end
    end
  end

  assign if_wait_cnt = if_wait_q;
  assign dm_wait_cnt = dm_wait_q;
`else
  assign if_wait_cnt = 32'd0;
  assign dm_wait_cnt = 32'd0;
`endif

endmodule
